// File: rtl/noc_switch_pkg.sv
// -----------------------------------------------------------------------------
// noc_switch_pkg
// Shared definitions for the NoC switch output demultiplexer:
//   FLIT_WIDTH  default flit width in bits
//   MAX_OUT     widest route-select vector onehot_lsb() accepts
//   onehot_lsb  lowest-set-bit one-hot mask of a route-select vector
//   clog2       ceiling log2, used for FIFO pointer sizing
// -----------------------------------------------------------------------------
package noc_switch_pkg;

  localparam int FLIT_WIDTH = 32;
  localparam int MAX_OUT    = 32;

  // x & -x isolates the lowest set bit; an all-zero vector stays all-zero.
  function automatic logic [MAX_OUT-1:0] onehot_lsb(input logic [MAX_OUT-1:0] vec);
    return vec & (~vec + MAX_OUT'(1));
  endfunction

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((longint'(1) << i) < longint'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/demux_fifo.sv
// -----------------------------------------------------------------------------
// demux_fifo
// Single-clock FIFO buffering the flits bound for one output channel.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data (ignored while full)
//   push_data    flit to store
//   pop          drop the head entry (ignored while empty)
//   full, empty  occupancy flags from registered pointers
//   head_data    oldest stored flit (stale content while empty)
// Pointers carry one extra wrap bit so all DEPTH slots are usable.
// -----------------------------------------------------------------------------
module demux_fifo
  import noc_switch_pkg::*;
#(
  parameter int WIDTH = FLIT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Same slot index with differing wrap bits means the writer lapped the reader.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is not reset; empty pointers make its content unobservable after reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/switch_demux_buf.sv
// -----------------------------------------------------------------------------
// switch_demux_buf
// Routes one flit stream to one of NUM_OUT output channels through a small
// per-output FIFO, so a stalled output never blocks flits for other outputs.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     input flit valid
//   in_ready     input accepts the flit (registered FIFO state + in_sel only)
//   in_data      input flit
//   in_sel       one-hot route select; lowest set bit wins, zero = discard
//   out_valid    per-output flit valid
//   out_ready    per-output consumer ready
//   out_data     flattened, channel i at [i*WIDTH +: WIDTH], zero when idle
//   drop_cnt     saturating count of discarded flits (DEMUX_DROP_CNT_EN only)
// Optional feature macro: DEMUX_DROP_CNT_EN.
// NUM_OUT is limited to MAX_OUT.
// -----------------------------------------------------------------------------
module switch_demux_buf
  import noc_switch_pkg::*;
#(
  parameter int WIDTH   = FLIT_WIDTH,
  parameter int NUM_OUT = 5,
  parameter int DEPTH   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [NUM_OUT-1:0]       in_sel,
  output logic [NUM_OUT-1:0]       out_valid,
  input  logic [NUM_OUT-1:0]       out_ready,
  output logic [NUM_OUT*WIDTH-1:0] out_data
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [15:0]              drop_cnt
`endif
);

  logic [MAX_OUT-1:0] sel_ext, sel_oh_full;
  logic [NUM_OUT-1:0] sel_oh;
  logic               no_route;
  logic               accept;
  logic [NUM_OUT-1:0] fifo_full, fifo_empty, push, pop;
  logic [WIDTH-1:0]   head [NUM_OUT];

  assign sel_ext     = MAX_OUT'(in_sel);
  assign sel_oh_full = onehot_lsb(sel_ext);
  assign sel_oh      = sel_oh_full[NUM_OUT-1:0];
  assign no_route    = ~|sel_oh_full;

  // Ready looks only at the target FIFO's registered full flag, never at
  // out_ready, so no combinational path runs from consumers to the producer.
  // Held low during reset even though the FIFOs read as empty then.
  assign in_ready = rst_n && (no_route || !(|(sel_oh & fifo_full)));
  assign accept   = in_valid && in_ready;

  assign push      = accept ? sel_oh : '0;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
    demux_fifo #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push[g]),
      .push_data (in_data),
      .pop       (pop[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g]),
      .head_data (head[g])
    );
  end

  // Idle channels drive zero rather than stale FIFO content.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_OUT; i++) begin
      if (!fifo_empty[i]) out_data[i*WIDTH +: WIDTH] = head[i];
    end
  end

`ifdef DEMUX_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (accept && no_route && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_switch_demux_buf.sv
// -----------------------------------------------------------------------------
// tb_switch_demux_buf
// Self-checking bench for switch_demux_buf. A queue-per-output model predicts
// every output each cycle; directed sequences pin the model with literal
// expectations, then a randomized phase exercises routing and back-pressure.
// Inputs change 1 ns after a rising edge; outputs are compared on the falling
// edge, after which the model applies the upcoming rising edge.
// -----------------------------------------------------------------------------
module tb_switch_demux_buf;

  localparam int WIDTH   = 32;
  localparam int NUM_OUT = 5;
  localparam int DEPTH   = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     in_valid = 1'b0;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_data = '0;
  logic [NUM_OUT-1:0]       in_sel = '0;
  logic [NUM_OUT-1:0]       out_valid;
  logic [NUM_OUT-1:0]       out_ready = '0;
  logic [NUM_OUT*WIDTH-1:0] out_data;
`ifdef DEMUX_DROP_CNT_EN
  logic [15:0]              drop_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  // Behavioural model: one FIFO queue per output plus a drop counter.
  logic [WIDTH-1:0] mq [NUM_OUT][$];
  int               m_drops = 0;

  always #5 clk = ~clk;

  switch_demux_buf #(
    .WIDTH   (WIDTH),
    .NUM_OUT (NUM_OUT),
    .DEPTH   (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // First index whose select bit is set, -1 when no route.
  function automatic int route_of(input logic [NUM_OUT-1:0] sel);
    for (int i = 0; i < NUM_OUT; i++) if (sel[i]) return i;
    return -1;
  endfunction

  // Per-cycle compare against the model, then advance the model one edge.
  always @(negedge clk) begin
    logic [NUM_OUT-1:0]       ev;
    logic [NUM_OUT*WIDTH-1:0] ed;
    logic                     er;
    int                       t;
    if (chk_en) begin
      if (!rst_n) begin
        for (int i = 0; i < NUM_OUT; i++) mq[i].delete();
        m_drops = 0;
        check("m_rst_valid", 256'(out_valid), 256'(0));
        check("m_rst_data",  256'(out_data),  256'(0));
        check("m_rst_ready", 256'(in_ready),  256'(0));
      end else begin
        ev = '0;
        ed = '0;
        for (int i = 0; i < NUM_OUT; i++) begin
          if (mq[i].size() > 0) begin
            ev[i] = 1'b1;
            ed[i*WIDTH +: WIDTH] = mq[i][0];
          end
        end
        check("m_out_valid", 256'(out_valid), 256'(ev));
        check("m_out_data",  256'(out_data),  256'(ed));
        t = route_of(in_sel);
        if (t < 0) er = 1'b1;
        else       er = (mq[t].size() < DEPTH);
        check("m_in_ready", 256'(in_ready), 256'(er));
`ifdef DEMUX_DROP_CNT_EN
        check("m_drop_cnt", 256'(drop_cnt), 256'(m_drops));
`endif
        for (int i = 0; i < NUM_OUT; i++) begin
          if (mq[i].size() > 0 && out_ready[i]) void'(mq[i].pop_front());
        end
        if (in_valid && er) begin
          if (t < 0) begin
            if (m_drops < 65535) m_drops++;
          end else begin
            mq[t].push_back(in_data);
          end
        end
      end
    end
  end

  task automatic set_in(input logic v, input logic [NUM_OUT-1:0] sel,
                        input logic [WIDTH-1:0] d, input logic [NUM_OUT-1:0] rdy);
    in_valid  = v;
    in_sel    = sel;
    in_data   = d;
    out_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NUM_OUT-1:0] sel, rdy;
    int                 r;

    // Reset: everything idle and in_ready low even for an unrouted flit.
    rst_n = 1'b0;
    tick();
    chk_en = 1'b1;
    set_in(1'b1, '0, 32'h1234_5678, '1);
    check("rst_valid", 256'(out_valid), 256'(0));
    check("rst_data",  256'(out_data),  256'(0));
    check("rst_ready", 256'(in_ready),  256'(0));
    tick();
    rst_n = 1'b1;
    set_in(1'b0, '0, '0, '0);
    tick();

    // Single routed flit, one cycle latency, other channels zero.
    set_in(1'b1, 5'b00100, 32'hA5A5_0001, '1);
    check("t1_ready", 256'(in_ready), 256'(1));
    tick();
    check("t1_valid", 256'(out_valid), 256'(5'b00100));
    check("t1_data",  256'(out_data),
          256'({32'h0, 32'h0, 32'hA5A5_0001, 32'h0, 32'h0}));
    set_in(1'b0, '0, '0, '1);
    tick();

    // Multi-hot select resolves to the lowest set bit only.
    set_in(1'b1, 5'b01010, 32'h0000_00FF, '0);
    tick();
    check("t2_valid", 256'(out_valid), 256'(5'b00010));
    check("t2_ch1",   256'(out_data[1*WIDTH +: WIDTH]), 256'(32'h0000_00FF));
    check("t2_ch3",   256'(out_data[3*WIDTH +: WIDTH]), 256'(0));
    set_in(1'b0, '0, '0, '1);
    tick();

    // Back-pressure on output 0: third flit refused until a slot frees.
    set_in(1'b1, 5'b00001, 32'hF000_0000, '0);
    tick();
    set_in(1'b1, 5'b00001, 32'hF000_0001, '0);
    check("t3_ready1", 256'(in_ready), 256'(1));
    tick();
    set_in(1'b1, 5'b00001, 32'hF000_0002, '0);
    check("t3_ready_full", 256'(in_ready), 256'(0));
    tick();
    check("t3_head0", 256'(out_data[0 +: WIDTH]), 256'(32'hF000_0000));
    set_in(1'b1, 5'b00001, 32'hF000_0002, 5'b00001);
    check("t3_ready_popcyc", 256'(in_ready), 256'(0));
    tick();
    check("t3_head1",  256'(out_data[0 +: WIDTH]), 256'(32'hF000_0001));
    check("t3_ready2", 256'(in_ready), 256'(1));
    tick();
    check("t3_head2", 256'(out_data[0 +: WIDTH]), 256'(32'hF000_0002));
    set_in(1'b0, '0, '0, 5'b00001);
    tick();
    check("t3_drained", 256'(out_valid), 256'(0));

    // No head-of-line blocking: output 0 full and stalled, output 4 flows.
    set_in(1'b1, 5'b00001, 32'hA000_0000, '0);
    tick();
    set_in(1'b1, 5'b00001, 32'hA000_0001, '0);
    tick();
    set_in(1'b1, 5'b10000, 32'hB000_0004, '0);
    check("t4_ready", 256'(in_ready), 256'(1));
    tick();
    check("t4_valid", 256'(out_valid), 256'(5'b10001));
    check("t4_ch4",   256'(out_data[4*WIDTH +: WIDTH]), 256'(32'hB000_0004));
    set_in(1'b0, '0, '0, '1);
    tick();
    tick();

    // Unrouted flits are consumed and discarded.
    set_in(1'b1, '0, 32'hDEAD_BEEF, '0);
    check("t5_ready", 256'(in_ready), 256'(1));
    repeat (3) tick();
    set_in(1'b0, '0, '0, '0);
    check("t5_valid", 256'(out_valid), 256'(0));
`ifdef DEMUX_DROP_CNT_EN
    check("t5_drop3", 256'(drop_cnt), 256'(16'd3));
    dut.drop_cnt_q = 16'hFFFE;
    m_drops = 65534;
    set_in(1'b1, '0, 32'hDEAD_0000, '0);
    repeat (3) tick();
    set_in(1'b0, '0, '0, '0);
    check("t5_drop_sat", 256'(drop_cnt), 256'(16'hFFFF));
`endif
    tick();

    // Randomized routing, back-pressure and drops against the model.
    for (int n = 0; n < 3000; n++) begin
      r = int'($urandom_range(0, 7));
      if (r == 0)     sel = '0;
      else if (r < 3) sel = NUM_OUT'($urandom);
      else            sel = NUM_OUT'(1) << $urandom_range(0, NUM_OUT - 1);
      for (int i = 0; i < NUM_OUT; i++) rdy[i] = ($urandom_range(0, 2) == 0);
      set_in(($urandom_range(0, 3) != 0), sel, $urandom, rdy);
      tick();
    end
    set_in(1'b0, '0, '0, '1);
    repeat (DEPTH + 1) tick();

    // Reset mid-burst with flits buffered on outputs 1 and 3.
    set_in(1'b1, 5'b00010, 32'hC000_0001, '0);
    tick();
    set_in(1'b1, 5'b01000, 32'hC000_0003, '0);
    tick();
    check("t6_buffered", 256'(out_valid), 256'(5'b01010));
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 256'(out_valid), 256'(0));
    check("t6_rst_data",  256'(out_data),  256'(0));
    check("t6_rst_ready", 256'(in_ready),  256'(0));
    tick();
    rst_n = 1'b1;
    set_in(1'b0, '0, '0, '0);
    tick();
    check("t6_after_valid", 256'(out_valid), 256'(0));
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/switch_demux_buf.md
Name: switch_demux_buf

Overview:
- Parametrised successor to the switch's 5-way one-hot output demultiplexer.
- Routes one input flit stream to one of NUM_OUT output channels, selected by a one-hot routing vector.
- Each output has its own small FIFO and a valid/ready handshake, so a stalled output port does not block flits bound for other ports.
- Sits between the router's route-compute stage and the per-direction output arbiters of a NoC switch.

Parameters:
- WIDTH, 32, flit width in bits.
- NUM_OUT, 5, number of output channels (>=2).
- DEPTH, 2, entries per output FIFO (power of 2, >=2).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input flit valid.
- in_ready  output  1  input can accept the flit on in_data/in_sel.
- in_data  input  WIDTH  input flit.
- in_sel  input  NUM_OUT  one-hot route select; bit i selects output i.
- out_valid  output  NUM_OUT  per-output flit valid.
- out_ready  input  NUM_OUT  per-output consumer ready.
- out_data  output  NUM_OUT*WIDTH  flattened; channel i occupies bits [i*WIDTH +: WIDTH].
- drop_cnt  output  16  dropped-flit count; present only with DEMUX_DROP_CNT_EN.

Behaviour:
- Reset (async assert, sync-safe deassert by upstream): all FIFOs empty, out_valid=0, out_data=0, drop_cnt=0, in_ready=0 while rst_n=0.
- Select decode:
  - Lowest set bit of in_sel wins; multi-hot sel is resolved to that single output, never duplicated.
  - in_sel==0 means no route: the flit is consumed with in_ready=1 and discarded.
- in_ready = !full[target] when in_sel!=0, else 1.
  - Depends only on registered FIFO state and in_sel, never on out_ready (no combinational ready path through the block).
- Accept on in_valid && in_ready: flit written to FIFO[target] at that clock edge.
- Latency: flit accepted at edge k gives out_valid[target]=1 after edge k; 1 cycle minimum.
- Per output i:
  - out_valid[i] = FIFO i non-empty.
  - out_data[i] = head entry when valid, else forced to all-zero, matching the previous demux's zero-idle behaviour.
  - Pop on out_valid[i] && out_ready[i].
- Simultaneous push and pop on the same FIFO:
  - Both happen in the same cycle; occupancy is unchanged.
  - When full, the push is still refused that cycle because in_ready was computed from full; the slot frees on the next cycle.
- Pointers: log2(DEPTH)+1 bits with natural wrap; full/empty from MSB compare; no dead entry, all DEPTH slots are usable.
- Ordering: FIFO order per output; no ordering guarantee across outputs.
- in_data/in_sel are don't-care when in_valid=0. in_valid may drop without acceptance; no stickiness is required of upstream.
- Reset mid-operation: all buffered flits are lost; outputs clear immediately on rst_n fall.

Optional Feature:
- Macro: DEMUX_DROP_CNT_EN.
- Defined:
  - drop_cnt increments by 1 on each accepted flit with in_sel==0.
  - Saturates at 16'hFFFF; cleared only by reset.
  - Registered; reflects a drop on the edge after it.
- Undefined: drop_cnt port and counter logic absent; unrouted flits are still silently consumed.

Decomposition:
- Package noc_switch_pkg:
  - flit width default constant;
  - function onehot_lsb(vector) returning the lowest-set-bit one-hot mask;
  - function clog2 for pointer sizing.
- Sub-module demux_fifo (WIDTH, DEPTH):
  - synchronous single-clock FIFO with push/pop, full/empty, head data, async active-low reset;
  - instantiated NUM_OUT times in a generate loop.
- Top level holds decode, in_ready mux, zero-masking of out_data, and the optional counter.

Test Plan:
- Reset, then in_valid=1, in_sel=5'b00100, data 32'hA5A5_0001 -> next cycle out_valid=5'b00100, channel 2 data A5A5_0001, all other channels 0.
- in_sel=5'b01010, data 32'h0000_00FF -> only out_valid[1]=1; channel 3 stays empty.
- Hold out_ready[0]=0, send 3 flits to output 0 with DEPTH=2 -> first 2 accepted, in_ready=0 on third. Then raise out_ready[0] -> flits pop in order, third accepted the cycle after the first pop.
- Output 0 full and stalled while a flit is sent to output 4 -> in_ready=1, flit appears on channel 4 next cycle (no head-of-line blocking).
- With DEMUX_DROP_CNT_EN, 3 accepted flits with in_sel=0 -> drop_cnt=3, no out_valid. Preload 16'hFFFE and drop 3 more -> drop_cnt=16'hFFFF.
- Assert rst_n=0 mid-burst with flits buffered on 2 outputs -> out_valid=0 and out_data=0 immediately, FIFOs empty after release.
